// File: rtl/jtag_host_sequencer.sv
// JTAG host sequencer: turns TAP-reset / IR-scan / DR-scan commands into registered
// TMS/TDI streams, captures TDO and mirrors the target TAP controller state.
module jtag_host_sequencer #(
    parameter int DR_MAX = 8
) (
    input  logic              TCK,
    input  logic              TRST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [3:0]        cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              rsp_err,
    output logic [3:0]        tap_state
);

    typedef enum logic [2:0] {INIT, IDLE, PRE, SHIFT, POST, RESP} host_state_t;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;

    localparam logic [3:0] TAP_TLR    = 4'd0;
    localparam logic [3:0] TAP_RTI    = 4'd1;
    localparam logic [3:0] TAP_SEL_DR = 4'd2;
    localparam logic [3:0] TAP_CAP_DR = 4'd3;
    localparam logic [3:0] TAP_SH_DR  = 4'd4;
    localparam logic [3:0] TAP_EX1_DR = 4'd5;
    localparam logic [3:0] TAP_PAU_DR = 4'd6;
    localparam logic [3:0] TAP_EX2_DR = 4'd7;
    localparam logic [3:0] TAP_UPD_DR = 4'd8;
    localparam logic [3:0] TAP_SEL_IR = 4'd9;
    localparam logic [3:0] TAP_CAP_IR = 4'd10;
    localparam logic [3:0] TAP_SH_IR  = 4'd11;
    localparam logic [3:0] TAP_EX1_IR = 4'd12;
    localparam logic [3:0] TAP_PAU_IR = 4'd13;
    localparam logic [3:0] TAP_EX2_IR = 4'd14;
    localparam logic [3:0] TAP_UPD_IR = 4'd15;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
        case (s)
            TAP_TLR:    tap_next = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    tap_next = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: tap_next = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: tap_next = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  tap_next = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: tap_next = tms ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: tap_next = tms ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: tap_next = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: tap_next = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: tap_next = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: tap_next = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  tap_next = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: tap_next = tms ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: tap_next = tms ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: tap_next = tms ? TAP_UPD_IR : TAP_SH_IR;
            default:    tap_next = tms ? TAP_SEL_DR : TAP_RTI;
        endcase
    endfunction

    // Preamble from RUN_TEST_IDLE: IR 1,1,0,0; DR 1,0,0; TAP reset 1,1,1,1,1,0.
    function automatic logic pre_tms(input logic [1:0] op, input logic [3:0] idx);
        case (op)
            OP_IR:   pre_tms = (idx < 4'd2);
            OP_DR:   pre_tms = (idx == 4'd0);
            default: pre_tms = (idx < 4'd5);
        endcase
    endfunction

    function automatic logic pre_last(input logic [1:0] op, input logic [3:0] idx);
        case (op)
            OP_IR:   pre_last = (idx == 4'd3);
            OP_DR:   pre_last = (idx == 4'd2);
            default: pre_last = (idx == 4'd5);
        endcase
    endfunction

    host_state_t       state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic [3:0]        idx_q;
    logic              shift_q, shift_d;
    logic              tms_d, tdi_d;
    logic              cmd_ok;
    logic [1:0]        op_q;
    logic [3:0]        len_q;
    logic [DR_MAX-1:0] data_q;
    logic [DR_MAX-1:0] data_sh;

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign data_sh   = data_q >> cnt;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        cmd_ok  = 1'b0;
        state_d = state;
        cnt_d   = cnt;
        tms_d   = 1'b0;
        tdi_d   = 1'b0;
        shift_d = 1'b0;

        case (cmd_op)
            OP_RESET: cmd_ok = 1'b1;
            OP_IR:    cmd_ok = (cmd_len == 4'd2);
            OP_DR:    cmd_ok = (cmd_len != 4'd0) && (int'(cmd_len) <= DR_MAX);
            default:  cmd_ok = 1'b0;
        endcase

        case (state)
            // Leave INIT only after one TMS=0 edge has walked the target out of TEST_LOGIC_RESET.
            INIT: if (!TMS) state_d = IDLE;
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_ok) begin
                        tms_d   = pre_tms(cmd_op, 4'd0);
                        cnt_d   = 4'd1;
                        state_d = PRE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            PRE: begin
                tms_d = pre_tms(op_q, cnt);
                cnt_d = cnt + 4'd1;
                if (pre_last(op_q, cnt)) begin
                    state_d = (op_q == OP_RESET) ? POST : SHIFT;
                    cnt_d   = (op_q == OP_RESET) ? 4'd2 : 4'd0;
                end
            end
            SHIFT: begin
                tdi_d   = data_sh[0];
                shift_d = 1'b1;
                tms_d   = (cnt == len_q - 4'd1);
                cnt_d   = cnt + 4'd1;
                if (cnt == len_q - 4'd1) begin
                    state_d = POST;
                    cnt_d   = 4'd0;
                end
            end
            // 1,0 to UPDATE and back to idle, then one more edge so the target is in RTI before rsp_valid.
            POST: begin
                tms_d = (cnt == 4'd0);
                cnt_d = cnt + 4'd1;
                if (cnt == 4'd2) state_d = RESP;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge TCK) begin
        if (TRST) begin
            state     <= INIT;
            cnt       <= 4'd0;
            idx_q     <= 4'd0;
            shift_q   <= 1'b0;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
            tap_state <= TAP_TLR;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees the pre-edge values of the others.
            state     <= state_d;
            cnt       <= cnt_d;
            idx_q     <= cnt;
            shift_q   <= shift_d;
            TMS       <= tms_d;
            TDI       <= tdi_d;
            tap_state <= tap_next(tap_state, TMS);
            if (state == IDLE && cmd_valid) begin
                rsp_data <= '0;
                rsp_err  <= ~cmd_ok;
            end else if (shift_q) begin
                rsp_data <= rsp_data | ({{(DR_MAX-1){1'b0}}, TDO} << idx_q);
            end
        end
    end

    // NOTE: command holding registers carry no reset; they are always loaded before they are read.
    always_ff @(posedge TCK) begin
        if (state == IDLE && cmd_valid) begin
            op_q   <= cmd_op;
            len_q  <= cmd_len;
            data_q <= cmd_data;
        end
    end

endmodule

// File: tb/tb_jtag_host_sequencer.sv
// Directed bench for jtag_host_sequencer against a small IEEE 1149.1 target model
// (2-bit IR capturing 01, every instruction selecting the 1-bit BYPASS register).
`timescale 1ns/1ps
module tb_jtag_host_sequencer;

    localparam int DR_MAX = 8;

    logic              TCK = 1'b0;
    logic              TRST = 1'b1;
    logic              cmd_valid, cmd_ready;
    logic [1:0]        cmd_op;
    logic [3:0]        cmd_len;
    logic [DR_MAX-1:0] cmd_data;
    logic              TMS, TDI, TDO;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [DR_MAX-1:0] rsp_data;
    logic [3:0]        tap_state;

    always #5 TCK = ~TCK;

    jtag_host_sequencer #(.DR_MAX(DR_MAX)) dut (
        .TCK(TCK), .TRST(TRST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .TMS(TMS), .TDI(TDI), .TDO(TDO),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .tap_state(tap_state)
    );

    // Target TAP model
    logic [3:0] tgt_state = 4'd0;
    logic [1:0] ir_sr = 2'b00;
    logic [1:0] ir = 2'b11;
    logic       byp = 1'b0;

    function automatic logic [3:0] tgt_next(input logic [3:0] s, input logic tms);
        logic [3:0] one [16];
        logic [3:0] zero [16];
        one  = '{4'd0, 4'd2, 4'd9, 4'd5, 4'd5, 4'd8, 4'd7, 4'd8,
                 4'd2, 4'd0, 4'd12, 4'd12, 4'd15, 4'd14, 4'd15, 4'd2};
        zero = '{4'd1, 4'd1, 4'd3, 4'd4, 4'd4, 4'd6, 4'd6, 4'd4,
                 4'd1, 4'd10, 4'd11, 4'd11, 4'd13, 4'd13, 4'd11, 4'd1};
        return tms ? one[s] : zero[s];
    endfunction

    assign TDO = (tgt_state == 4'd11) ? ir_sr[0] :
                 (tgt_state == 4'd4)  ? byp      : 1'b0;

    always @(posedge TCK) begin
        case (tgt_state)
            4'd3:    byp   <= 1'b0;
            4'd4:    byp   <= TDI;
            4'd10:   ir_sr <= 2'b01;
            4'd11:   ir_sr <= {TDI, ir_sr[1]};
            4'd15:   ir    <= ir_sr;
            default: ;
        endcase
        tgt_state <= tgt_next(tgt_state, TMS !== 1'b0);
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int          n_tms;
    logic [31:0] tms_tr;
    logic [63:0] tap_tr;
    int          tap_mis;

    // Offer one command at the current negedge, then record TMS/tap_state each cycle until rsp_valid.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] len, input logic [7:0] data,
                           input string tag);
        n_tms = 0; tms_tr = '0; tap_tr = '0; tap_mis = 0;
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
        @(negedge TCK);
        cmd_valid = 1'b0; cmd_op = 2'b11; cmd_len = 4'hf; cmd_data = 8'hff;
        for (int i = 0; i < 40 && !rsp_valid; i++) begin
            tms_tr = {tms_tr[30:0], TMS};
            tap_tr = {tap_tr[59:0], tap_state};
            n_tms++;
            if (tap_state !== tgt_state) tap_mis++;
            @(negedge TCK);
        end
        tap_tr = {tap_tr[59:0], tap_state};
        check({tag, "_rsp_valid"}, rsp_valid, 1);
    endtask

    task automatic consume(input string tag);
        @(negedge TCK);
        check({tag, "_rsp_gone"}, rsp_valid, 0);
        check({tag, "_ready_back"}, cmd_ready, 1);
    endtask

    initial begin
        int cnt_bad;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 4'd0; cmd_data = '0; rsp_ready = 1'b1;

        // Reset and idle
        TRST = 1'b1;
        repeat (6) @(negedge TCK);
        check("rst_tms", TMS, 1);
        check("rst_tdi", TDI, 0);
        check("rst_tap", tap_state, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_data", rsp_data, 0);
        TRST = 1'b0;
        @(negedge TCK);
        check("init_tms", TMS, 0);
        check("init_cmd_ready", cmd_ready, 0);
        @(negedge TCK);
        check("idle_tap", tap_state, 1);
        check("idle_cmd_ready", cmd_ready, 1);
        cnt_bad = 0;
        repeat (4) begin
            @(negedge TCK);
            if (TMS !== 1'b0 || tap_state !== 4'd1) cnt_bad++;
        end
        check("idle_steady", cnt_bad, 0);

        // IR scan, data 00
        run_cmd(2'b01, 4'd2, 8'h00, "ir00");
        check("ir00_ncyc", n_tms, 8);
        check("ir00_tms", tms_tr, 32'hC6);
        check("ir00_tap", tap_tr, 64'h129ABBCF1);
        check("ir00_tap_vs_tgt", tap_mis, 0);
        check("ir00_err", rsp_err, 0);
        check("ir00_data", rsp_data, 8'h01);
        check("ir00_tgt_ir", ir, 2'b00);
        consume("ir00");

        // BYPASS then DR scan 0xAA
        run_cmd(2'b01, 4'd2, 8'h03, "ir11");
        check("ir11_tgt_ir", ir, 2'b11);
        consume("ir11");
        run_cmd(2'b10, 4'd8, 8'hAA, "dr_aa");
        check("dr_aa_ncyc", n_tms, 13);
        check("dr_aa_tms", tms_tr, 32'h1006);
        check("dr_aa_tap", tap_tr, 64'h12344444444581);
        check("dr_aa_tap_vs_tgt", tap_mis, 0);
        check("dr_aa_data", rsp_data, 8'h54);
        check("dr_aa_err", rsp_err, 0);
        consume("dr_aa");

        // Shortest DR scan
        run_cmd(2'b10, 4'd1, 8'h01, "dr_len1");
        check("dr_len1_ncyc", n_tms, 6);
        check("dr_len1_tms", tms_tr, 32'h26);
        check("dr_len1_data", rsp_data, 8'h00);
        consume("dr_len1");

        // Rejected commands
        run_cmd(2'b11, 4'd8, 8'h5A, "op11");
        check("op11_ncyc", n_tms, 0);
        check("op11_err", rsp_err, 1);
        check("op11_data", rsp_data, 0);
        check("op11_tms", TMS, 0);
        check("op11_tap", tap_state, 1);
        consume("op11");
        run_cmd(2'b10, 4'd0, 8'h5A, "dr_len0");
        check("dr_len0_ncyc", n_tms, 0);
        check("dr_len0_err", rsp_err, 1);
        check("dr_len0_data", rsp_data, 0);
        consume("dr_len0");
        run_cmd(2'b01, 4'd3, 8'h05, "ir_len3");
        check("ir_len3_err", rsp_err, 1);
        check("ir_len3_ncyc", n_tms, 0);
        consume("ir_len3");
        run_cmd(2'b10, 4'd9, 8'hFF, "dr_len9");
        check("dr_len9_err", rsp_err, 1);
        check("dr_len9_ncyc", n_tms, 0);
        check("dr_len9_tap", tap_state, 1);
        consume("dr_len9");

        // TAP reset op
        run_cmd(2'b00, 4'd0, 8'h77, "tapreset");
        check("tapreset_ncyc", n_tms, 6);
        check("tapreset_tms", tms_tr, 32'h3E);
        check("tapreset_tap", tap_tr, 64'h1290001);
        check("tapreset_err", rsp_err, 0);
        check("tapreset_data", rsp_data, 0);
        consume("tapreset");

        // Response back-pressure with a command offered meanwhile
        rsp_ready = 1'b0;
        run_cmd(2'b10, 4'd8, 8'h0F, "hold");
        check("hold_data", rsp_data, 8'h1E);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 4'd2; cmd_data = 8'h00;
        cnt_bad = 0;
        repeat (10) begin
            @(negedge TCK);
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h1E || rsp_err !== 1'b0 ||
                cmd_ready !== 1'b0 || TMS !== 1'b0 || tap_state !== 4'd1) cnt_bad++;
        end
        check("hold_stable", cnt_bad, 0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        consume("hold");
        @(negedge TCK);
        check("hold_no_cmd_tms", TMS, 0);
        check("hold_no_cmd_tap", tap_state, 1);

        // TRST during the 4th SHIFT_DR bit
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 4'd8; cmd_data = 8'h08;
        @(negedge TCK);
        cmd_valid = 1'b0;
        repeat (6) @(negedge TCK);
        check("abort_in_shift", tap_state, 4);
        check("abort_tdi_bit3", TDI, 1);
        TRST = 1'b1;
        cnt_bad = 0;
        repeat (8) begin
            @(negedge TCK);
            if (rsp_valid !== 1'b0) cnt_bad++;
        end
        check("abort_no_rsp", cnt_bad, 0);
        check("abort_tap", tap_state, 0);
        check("abort_tms", TMS, 1);
        check("abort_tgt_tlr", tgt_state, 0);
        check("abort_cmd_ready", cmd_ready, 0);
        TRST = 1'b0;
        @(negedge TCK);
        check("reinit_tms", TMS, 0);
        check("reinit_cmd_ready", cmd_ready, 0);
        @(negedge TCK);
        check("reinit_tap", tap_state, 1);
        check("reinit_cmd_ready_up", cmd_ready, 1);
        run_cmd(2'b01, 4'd2, 8'h00, "ir_after");
        check("ir_after_tms", tms_tr, 32'hC6);
        check("ir_after_data", rsp_data, 8'h01);
        check("ir_after_tap_vs_tgt", tap_mis, 0);
        check("ir_after_err", rsp_err, 0);
        consume("ir_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
